// File: rtl/sap1_controller.sv
// rtl/sap1_controller.sv - SAP-1 T-state sequencer and control word decoder
module sap1_controller #(
  parameter logic [3:0] OP_LDA     = 4'h0,
  parameter logic [3:0] OP_ADD     = 4'h1,
  parameter logic [3:0] OP_SUB     = 4'h2,
  parameter logic [3:0] OP_OUT     = 4'hE,
  parameter logic [3:0] OP_HLT     = 4'hF,
  parameter bit         EARLY_EXIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       pc_inc,
  output logic       pc_en,
  output logic       mar_load,
  output logic       mem_en,
  output logic       ir_load,
  output logic       ir_en,
  output logic       a_load,
  output logic       a_en,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_en,
  output logic       out_load,
  output logic       halted,
  output logic [2:0] t_state
);

  // State 0 doubles as the post-reset recovery cycle and the parked halt state.
  localparam logic [2:0] T_IDLE = 3'd0;
  localparam logic [2:0] T1     = 3'd1;
  localparam logic [2:0] T2     = 3'd2;
  localparam logic [2:0] T3     = 3'd3;
  localparam logic [2:0] T4     = 3'd4;
  localparam logic [2:0] T5     = 3'd5;
  localparam logic [2:0] T6     = 3'd6;

  logic [2:0] t_next;
  logic       halted_next;
  logic       is_lda, is_add, is_sub, is_out, is_hlt, is_nop;

  assign is_lda = (opcode == OP_LDA);
  assign is_add = (opcode == OP_ADD);
  assign is_sub = (opcode == OP_SUB);
  assign is_out = (opcode == OP_OUT);
  assign is_hlt = (opcode == OP_HLT);
  assign is_nop = !(is_lda || is_add || is_sub || is_out || is_hlt);

  // Step and halt registers; reset parks the ring in the recovery state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_state <= T_IDLE;
      halted  <= 1'b0;
    end else begin
      t_state <= t_next;
      halted  <= halted_next;
    end
  end

  // Microcode decode and next-step selection from {t_state, opcode, halted}.
  always_comb begin
    t_next      = t_state;
    halted_next = halted;
    pc_inc      = 1'b0;
    pc_en       = 1'b0;
    mar_load    = 1'b0;
    mem_en      = 1'b0;
    ir_load     = 1'b0;
    ir_en       = 1'b0;
    a_load      = 1'b0;
    a_en        = 1'b0;
    b_load      = 1'b0;
    alu_sub     = 1'b0;
    alu_en      = 1'b0;
    out_load    = 1'b0;
    if (!halted) begin
      case (t_state)
        T_IDLE: t_next = T1;
        T1: begin
          pc_en    = 1'b1;
          mar_load = 1'b1;
          t_next   = T2;
        end
        T2: begin
          pc_inc = 1'b1;
          t_next = T3;
        end
        T3: begin
          mem_en  = 1'b1;
          ir_load = 1'b1;
          t_next  = T4;
        end
        T4: begin
          t_next = T5;
          if (is_lda || is_add || is_sub) begin
            ir_en    = 1'b1;
            mar_load = 1'b1;
          end else if (is_out) begin
            a_en     = 1'b1;
            out_load = 1'b1;
          end
          // Halt wins over everything: park in state 0 for good.
          if (is_hlt) begin
            t_next      = T_IDLE;
            halted_next = 1'b1;
          end else if (EARLY_EXIT && (is_out || is_nop)) begin
            t_next = T1;
          end
        end
        T5: begin
          t_next = T6;
          if (is_lda) begin
            mem_en = 1'b1;
            a_load = 1'b1;
            if (EARLY_EXIT) t_next = T1;
          end else if (is_add || is_sub) begin
            mem_en = 1'b1;
            b_load = 1'b1;
          end
        end
        T6: begin
          t_next = T1;
          if (is_add || is_sub) begin
            alu_en  = 1'b1;
            alu_sub = is_sub;
            a_load  = 1'b1;
          end
        end
        default: t_next = T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sap1_controller.sv
// tb/tb_sap1_controller.sv - directed self-checking bench for sap1_controller
module tb_sap1_controller;

  // Control word packing: {pc_inc,pc_en,mar_load,mem_en,ir_load,ir_en,a_load,a_en,b_load,alu_sub,alu_en,out_load}
  localparam logic [11:0] C_PC_INC = 12'h800;
  localparam logic [11:0] C_PC_EN  = 12'h400;
  localparam logic [11:0] C_MAR    = 12'h200;
  localparam logic [11:0] C_MEM    = 12'h100;
  localparam logic [11:0] C_IR_LD  = 12'h080;
  localparam logic [11:0] C_IR_EN  = 12'h040;
  localparam logic [11:0] C_A_LD   = 12'h020;
  localparam logic [11:0] C_A_EN   = 12'h010;
  localparam logic [11:0] C_B_LD   = 12'h008;
  localparam logic [11:0] C_SUB    = 12'h004;
  localparam logic [11:0] C_ALU    = 12'h002;
  localparam logic [11:0] C_OUT    = 12'h001;
  localparam logic [11:0] BUS_DRV  = C_PC_EN | C_MEM | C_IR_EN | C_A_EN | C_ALU;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  wire [11:0] c0, c1;
  wire [2:0]  t0, t1;
  wire        h0, h1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  sap1_controller #(.EARLY_EXIT(1'b0)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_inc(c0[11]), .pc_en(c0[10]), .mar_load(c0[9]), .mem_en(c0[8]),
    .ir_load(c0[7]), .ir_en(c0[6]), .a_load(c0[5]), .a_en(c0[4]),
    .b_load(c0[3]), .alu_sub(c0[2]), .alu_en(c0[1]), .out_load(c0[0]),
    .halted(h0), .t_state(t0)
  );

  sap1_controller #(.EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pc_inc(c1[11]), .pc_en(c1[10]), .mar_load(c1[9]), .mem_en(c1[8]),
    .ir_load(c1[7]), .ir_en(c1[6]), .a_load(c1[5]), .a_en(c1[4]),
    .b_load(c1[3]), .alu_sub(c1[2]), .alu_en(c1[1]), .out_load(c1[0]),
    .halted(h1), .t_state(t1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: compare at the falling edge, then advance to just past the next rising edge.
  task automatic cyc(input string tag, input bit sel, input logic [2:0] et, input logic [11:0] ec);
    @(negedge clk);
    check({tag, "_t"}, sel ? t1 : t0, et);
    check({tag, "_c"}, sel ? c1 : c0, ec);
    @(posedge clk);
    #1;
  endtask

  // Runs steps 1..n of one instruction; during fetch the opcode input carries junk.
  task automatic run_ins(input string tag, input bit sel, input logic [3:0] op,
                         input logic [11:0] e4, input logic [11:0] e5, input logic [11:0] e6,
                         input int n);
    logic [11:0] exp_c [1:6];
    exp_c[1] = C_PC_EN | C_MAR;
    exp_c[2] = C_PC_INC;
    exp_c[3] = C_MEM | C_IR_LD;
    exp_c[4] = e4;
    exp_c[5] = e5;
    exp_c[6] = e6;
    for (int k = 1; k <= n; k++) begin
      opcode = (k <= 3) ? (op ^ 4'hF) : op;
      cyc($sformatf("%s_T%0d", tag, k), sel, 3'(k), exp_c[k]);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_c0"}, c0, 12'h000);
    check({tag, "_rst_c1"}, c1, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_rst_t0"}, t0, 3'd0);
    check({tag, "_rst_h0"}, h0, 1'b0);
    check({tag, "_rst_h1"}, h1, 1'b0);
    rst = 1'b0;
    cyc({tag, "_rec"}, 1'b0, 3'd0, 12'h000);
  endtask

  // Bus single-driver and alu_sub-implies-alu_en on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      check("bus1_dut", 32'($countones(c0 & BUS_DRV) <= 1), 32'd1);
      check("bus1_ee", 32'($countones(c1 & BUS_DRV) <= 1), 32'd1);
      check("subalu_dut", 32'(!(c0[2] && !c0[1])), 32'd1);
      check("subalu_ee", 32'(!(c1[2] && !c1[1])), 32'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset("r1");

    // Program LDA, ADD, SUB, HLT on the full-length sequencer.
    run_ins("lda", 1'b0, 4'h0, C_IR_EN | C_MAR, C_MEM | C_A_LD, 12'h000, 6);
    run_ins("add", 1'b0, 4'h1, C_IR_EN | C_MAR, C_MEM | C_B_LD, C_ALU | C_A_LD, 6);
    run_ins("sub", 1'b0, 4'h2, C_IR_EN | C_MAR, C_MEM | C_B_LD, C_ALU | C_SUB | C_A_LD, 6);
    run_ins("hlt", 1'b0, 4'hF, 12'h000, 12'h000, 12'h000, 4);
    check("hlt_set", h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      opcode = 4'(i);
      cyc("halted", 1'b0, 3'd0, 12'h000);
    end
    check("hlt_sticky", h0, 1'b1);

    do_reset("r2");
    run_ins("out", 1'b0, 4'hE, C_A_EN | C_OUT, 12'h000, 12'h000, 6);
    run_ins("nop", 1'b0, 4'h7, 12'h000, 12'h000, 12'h000, 6);

    // Asynchronous reset in the middle of ADD step 5.
    run_ins("addr", 1'b0, 4'h1, C_IR_EN | C_MAR, C_MEM | C_B_LD, C_ALU | C_A_LD, 4);
    @(negedge clk);
    check("midT5_t", t0, 3'd5);
    check("midT5_bload", c0[3], 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("async_c", c0, 12'h000);
    check("async_t", t0, 3'd0);
    @(posedge clk);
    #1;
    do_reset("r3");
    run_ins("lda2", 1'b0, 4'h0, C_IR_EN | C_MAR, C_MEM | C_A_LD, 12'h000, 6);

    // Early-exit instance: shortened LDA, OUT and NOP; ADD/SUB full length.
    do_reset("r4");
    cyc("ee_T1chk", 1'b1, 3'd1, C_PC_EN | C_MAR);
    do_reset("r5");
    run_ins("ee_lda", 1'b1, 4'h0, C_IR_EN | C_MAR, C_MEM | C_A_LD, 12'h000, 5);
    run_ins("ee_out", 1'b1, 4'hE, C_A_EN | C_OUT, 12'h000, 12'h000, 4);
    run_ins("ee_nop", 1'b1, 4'h9, 12'h000, 12'h000, 12'h000, 4);
    run_ins("ee_sub", 1'b1, 4'h2, C_IR_EN | C_MAR, C_MEM | C_B_LD, C_ALU | C_SUB | C_A_LD, 6);
    run_ins("ee_add", 1'b1, 4'h1, C_IR_EN | C_MAR, C_MEM | C_B_LD, C_ALU | C_A_LD, 6);
    run_ins("ee_hlt", 1'b1, 4'hF, 12'h000, 12'h000, 12'h000, 4);
    check("ee_hlt_set", h1, 1'b1);
    cyc("ee_halted", 1'b1, 3'd0, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
